pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_ctrl_sb_entry.sv | 36 +++
 rtl/pipe_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, state encodings and types for the pipeline hazard / flush controller.
// The sizes and state codes are plain defines so any file of the core can pick them up.
`ifndef PIPE_CTRL_SIZES
`define PIPE_CTRL_SIZES
`define SIZE_ADDR     16
`define HBIT_ADDR     15
`define SIZE_SRC_GP   5
`define HBIT_SRC_GP   4
`define SIZE_TGT_GP   `SIZE_SRC_GP
`define HBIT_TGT_GP   `HBIT_SRC_GP
`define STATE_RUN     2'b00
`define STATE_STALL   2'b01
`define STATE_FREEZE  2'b10
`endif

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = `STATE_RUN,
        ST_STALL  = `STATE_STALL,
        ST_FREEZE = `STATE_FREEZE
    } state_e;

    typedef enum logic [1:0] {
        DEC_RUN,
        DEC_STALL,
        DEC_FREEZE,
        DEC_FLUSH
    } decision_e;

    typedef struct packed {
        logic                 v;
        logic [`HBIT_TGT_GP:0] tgt;
    } sb_entry_t;

    // A flush only redirects fetch; the pipeline is otherwise running.
    function automatic state_e report_state(decision_e d);
        case (d)
            DEC_STALL:  return ST_STALL;
            DEC_FREEZE: return ST_FREEZE;
            default:    return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/EX/MA facing signals of the pipeline controller; the pipeline side is master,
// the controller is slave.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                  iw_id_valid;
    logic [`HBIT_SRC_GP:0] iw_id_src_gp;
    logic                  iw_id_src_en;
    logic [`HBIT_TGT_GP:0] iw_id_tgt_gp;
    logic                  iw_id_tgt_en;
    logic                  iw_br_taken;
    logic [`HBIT_ADDR:0]   iw_br_pc;
    logic                  iw_mem_busy;

    logic                  ow_stall_if;
    logic                  ow_stall_id;
    logic                  ow_bubble_ex;
    logic                  ow_flush_if;
    logic                  ow_flush_id;
    logic                  ow_pc_load;
    logic [`HBIT_ADDR:0]   ow_pc_tgt;
    state_e                ow_state;
    logic [15:0]           ow_stall_cnt;

    modport master (
        output iw_id_valid, iw_id_src_gp, iw_id_src_en, iw_id_tgt_gp, iw_id_tgt_en,
               iw_br_taken, iw_br_pc, iw_mem_busy,
        input  ow_stall_if, ow_stall_id, ow_bubble_ex, ow_flush_if, ow_flush_id,
               ow_pc_load, ow_pc_tgt, ow_state, ow_stall_cnt
    );

    modport slave (
        input  iw_id_valid, iw_id_src_gp, iw_id_src_en, iw_id_tgt_gp, iw_id_tgt_en,
               iw_br_taken, iw_br_pc, iw_mem_busy,
        output ow_stall_if, ow_stall_id, ow_bubble_ex, ow_flush_if, ow_flush_id,
               ow_pc_load, ow_pc_tgt, ow_state, ow_stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_sb_entry.sv
// One scoreboard slot: holds {v, tgt} of an instruction past decode and flags when
// the decode source register matches it.
module pipe_sb_entry
    import pipe_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  hold,
    input  sb_entry_t             d,
    input  logic [`HBIT_SRC_GP:0] src_gp,
    output sb_entry_t             q,
    output logic                  match
);

    sb_entry_t entry_q;
    sb_entry_t entry_d;

    always_comb begin
        entry_d = d;
        if (hold) begin
            entry_d = entry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q     = entry_q;
    assign match = entry_q.v & (entry_q.tgt == src_gp);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-cycle freeze / flush / stall / run decision from a three-deep
// register scoreboard, plus a registered state report and a saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        iw_clk,
    input  logic        iw_rst,
    pipe_ctrl_if.slave  bus
);

    sb_entry_t   ex_d;
    sb_entry_t   ex_q;
    sb_entry_t   ma_q;
    sb_entry_t   wb_unused;
    logic        ex_match;
    logic        ma_match;
    logic        wb_match;
    logic        hazard;
    logic        sb_hold;
    decision_e   decision;
    state_e      state_q;
    state_e      state_d;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    assign hazard = bus.iw_id_valid & bus.iw_id_src_en & (ex_match | ma_match | wb_match);

    always_comb begin
        decision = DEC_RUN;
        if (bus.iw_mem_busy) begin
            decision = DEC_FREEZE;
        end else if (bus.iw_br_taken) begin
            decision = DEC_FLUSH;
        end else if (hazard) begin
            decision = DEC_STALL;
        end
    end

    // Only a RUN decision lets the decode instruction enter EX; anything else inserts a bubble.
    always_comb begin
        ex_d = '0;
        if (decision == DEC_RUN) begin
            ex_d.v   = bus.iw_id_valid & bus.iw_id_tgt_en;
            ex_d.tgt = bus.iw_id_tgt_gp;
        end
    end

    assign sb_hold = (decision == DEC_FREEZE);

    pipe_sb_entry u_sb_ex (
        .clk    (iw_clk),
        .clear  (iw_rst),
        .hold   (sb_hold),
        .d      (ex_d),
        .src_gp (bus.iw_id_src_gp),
        .q      (ex_q),
        .match  (ex_match)
    );

    pipe_sb_entry u_sb_ma (
        .clk    (iw_clk),
        .clear  (iw_rst),
        .hold   (sb_hold),
        .d      (ex_q),
        .src_gp (bus.iw_id_src_gp),
        .q      (ma_q),
        .match  (ma_match)
    );

    pipe_sb_entry u_sb_wb (
        .clk    (iw_clk),
        .clear  (iw_rst),
        .hold   (sb_hold),
        .d      (ma_q),
        .src_gp (bus.iw_id_src_gp),
        .q      (wb_unused),
        .match  (wb_match)
    );

    // Reset overrides every input so the front end is flushed while held in reset.
    always_comb begin
        bus.ow_stall_if  = 1'b0;
        bus.ow_stall_id  = 1'b0;
        bus.ow_bubble_ex = 1'b0;
        bus.ow_flush_if  = 1'b0;
        bus.ow_flush_id  = 1'b0;
        bus.ow_pc_load   = 1'b0;
        bus.ow_pc_tgt    = '0;
        if (iw_rst) begin
            bus.ow_flush_if = 1'b1;
            bus.ow_flush_id = 1'b1;
        end else begin
            case (decision)
                DEC_FREEZE: begin
                    bus.ow_stall_if = 1'b1;
                    bus.ow_stall_id = 1'b1;
                end
                DEC_FLUSH: begin
                    bus.ow_flush_if  = 1'b1;
                    bus.ow_flush_id  = 1'b1;
                    bus.ow_pc_load   = 1'b1;
                    bus.ow_pc_tgt    = bus.iw_br_pc;
                    bus.ow_bubble_ex = 1'b1;
                end
                DEC_STALL: begin
                    bus.ow_stall_if  = 1'b1;
                    bus.ow_stall_id  = 1'b1;
                    bus.ow_bubble_ex = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_d     = report_state(decision);
        stall_cnt_d = stall_cnt_q;
        if ((decision == DEC_STALL) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ow_state     = state_q;
    assign bus.ow_stall_cnt = stall_cnt_q;

endmodule
